// File: rtl/fetch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_pkg : shared types and constants for the instruction fetch    |
// | Revision  : 1.0                                                     |
// +--------------------------------------------------------------------+
package fetch_pkg;

   localparam logic [31:0] EOF_WORD    = 32'hDEADBEEF;
   localparam logic [31:0] INSTR_BYTES = 32'd4;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      HALT  = 2'd1,
      FAULT = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_entry_t;

   function automatic logic is_aligned(input logic [31:0] addr);
      return (addr[1:0] == 2'b00);
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_fifo : synchronous prefetch FIFO of fetch_entry_t with flush  |
// | Revision   : 1.0                                                    |
// +--------------------------------------------------------------------+
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t wdata,
   output logic         full,
   output logic         empty,
   output fetch_entry_t head
);

   localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [c_aw:0] c_full_cnt = (c_aw+1)'(DEPTH);

   fetch_entry_t    r_mem [DEPTH];
   logic [c_aw-1:0] r_wr_ptr;
   logic [c_aw-1:0] r_rd_ptr;
   logic [c_aw:0]   r_count;
   logic            w_do_push;
   logic            w_do_pop;

   // A push into a full FIFO is legal only when the head leaves this cycle.
   assign w_do_push = push & (~full | pop);
   assign w_do_pop  = pop & ~empty;

   assign full  = (r_count == c_full_cnt);
   assign empty = (r_count == '0);
   assign head  = r_mem[r_rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + (c_aw+1)'(1);
            2'b01:   r_count <= r_count - (c_aw+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push && !flush) r_mem[r_wr_ptr] <= wdata;
   end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | instr_fetch_ctrl : PC sequencer + prefetch FIFO in front of imem.   |
// | Optional macro FETCH_PERF_EN adds fetch/stall performance counters. |
// | Revision         : 1.0                                              |
// +--------------------------------------------------------------------+
module instr_fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        halted,
   output logic        fault
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_stall_cnt
`endif
);

   fetch_state_e r_state;
   fetch_state_e w_state_nxt;
   logic [31:0]  r_pc;
   logic [31:0]  w_pc_nxt;
   logic         w_full;
   logic         w_empty;
   logic         w_pop_req;
   logic         w_pop;
   logic         w_fetch;
   logic         w_is_eof;
   logic         w_push;
   fetch_entry_t w_wdata;
   fetch_entry_t w_head;

   assign w_pop_req = out_valid & out_ready;
   assign w_fetch   = (r_state == RUN) & ~redirect_valid & (~w_full | w_pop_req);
   assign w_is_eof  = (imem_instr == EOF_WORD);
   assign w_push    = w_fetch & ~w_is_eof;
   // A redirect discards whatever decode tried to take this cycle.
   assign w_pop     = w_pop_req & ~redirect_valid;

   assign w_wdata.instr = imem_instr;
   assign w_wdata.pc    = r_pc;

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (w_push),
      .pop   (w_pop),
      .flush (redirect_valid),
      .wdata (w_wdata),
      .full  (w_full),
      .empty (w_empty),
      .head  (w_head)
   );

   assign imem_addr = r_pc;
   assign out_valid = ~w_empty;
   assign out_instr = w_head.instr;
   assign out_pc    = w_head.pc;
   assign halted    = (r_state == HALT);
   assign fault     = (r_state == FAULT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= RUN;
         r_pc    <= RESET_PC;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      if (redirect_valid) begin
         w_pc_nxt    = redirect_pc;
         w_state_nxt = is_aligned(redirect_pc) ? RUN : FAULT;
      end else if (w_fetch) begin
         if (w_is_eof) begin
            w_state_nxt = HALT;
         end else begin
            w_pc_nxt = r_pc + INSTR_BYTES;
         end
      end
   end

`ifdef FETCH_PERF_EN
   logic r_unused_perf;
   logic w_stall;

   assign w_stall = (r_state == RUN) & w_full & ~w_pop_req & ~redirect_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetch_cnt <= '0;
         perf_stall_cnt <= '0;
         r_unused_perf  <= 1'b0;
      end else begin
         if (w_push)  perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
         if (w_stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
         r_unused_perf <= 1'b0;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_instr_fetch_ctrl : scoreboard bench for instr_fetch_ctrl         |
// | Revision            : 1.0                                           |
// +--------------------------------------------------------------------+
module tb_instr_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halted;
   logic        fault;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_stall_cnt;
`endif

   logic [31:0] eof_addr;
   logic [63:0] exp_q [$];
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   // Memory image: word at address a is {a[15:0], 16'h0013}, sentinel at eof_addr.
   assign imem_instr = (imem_addr == eof_addr) ? 32'hDEADBEEF : {imem_addr[15:0], 16'h0013};

   instr_fetch_ctrl #(
      .RESET_PC (32'h0000_0000),
      .DEPTH    (4)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_addr      (imem_addr),
      .imem_instr     (imem_instr),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halted         (halted),
      .fault          (fault)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_stall_cnt (perf_stall_cnt)
`endif
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic exp_push(input logic [31:0] pc);
      exp_q.push_back({pc[15:0], 16'h0013, pc});
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic ready);
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      out_ready      = ready;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Monitor: every accepted head must match the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready && !redirect_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_pop", {out_instr, out_pc}, 64'h0);
            if ({out_instr, out_pc} === 64'h0) begin
               errors++;
               $display("FAIL unexpected_pop: got pop with empty scoreboard");
            end
         end else begin
            chk("head_entry", {out_instr, out_pc}, exp_q.pop_front());
         end
      end
   end

   initial begin
      eof_addr = 32'hFFFF_FFFF;

      // Reset state and streaming at full rate
      do_reset(1'b1);
      chk("reset_addr", 64'(imem_addr), 64'h0);
      chk("reset_halted_fault", {62'h0, halted, fault}, 64'h0);
      @(negedge clk);
      chk("first_cycle_valid", 64'(out_valid), 64'h0);
      for (int i = 0; i < 8; i++) exp_push(32'(4 * i));
      @(posedge clk);
      #1;
      step(8);
      out_ready = 1'b0;
      chk("stream_drained", 64'(exp_q.size()), 64'h0);

      // Backpressure: fill, stall, then one-in one-out
      do_reset(1'b0);
      step(7);
      chk("stall_addr", 64'(imem_addr), 64'h10);
      chk("stall_head", {31'h0, out_valid, out_pc}, {31'h0, 1'b1, 32'h0});
`ifdef FETCH_PERF_EN
      chk("perf_fetch", 64'(perf_fetch_cnt), 64'd4);
      chk("perf_stall", 64'(perf_stall_cnt), 64'd3);
`endif
      for (int i = 0; i < 16; i++) exp_push(32'(4 * i));
      out_ready = 1'b1;
      step(16);
      out_ready = 1'b0;
      chk("stall_drained", 64'(exp_q.size()), 64'h0);

      // Redirect with three entries buffered, pop discarded
      do_reset(1'b0);
      step(3);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h40;
      out_ready      = 1'b1;
      step(1);
      redirect_valid = 1'b0;
      chk("redirect_valid_drop", 64'(out_valid), 64'h0);
      chk("redirect_addr", 64'(imem_addr), 64'h40);
      exp_push(32'h40);
      exp_push(32'h44);
      exp_push(32'h48);
      step(4);
      out_ready = 1'b0;
      chk("redirect_drained", 64'(exp_q.size()), 64'h0);

      // End-of-image sentinel halts, aligned redirect resumes
      eof_addr = 32'h0C;
      do_reset(1'b1);
      exp_push(32'h0);
      exp_push(32'h4);
      exp_push(32'h8);
      step(6);
      chk("eof_halted", {62'h0, halted, out_valid}, {62'h0, 1'b1, 1'b0});
      chk("eof_addr_hold", 64'(imem_addr), 64'h0C);
      chk("eof_drained", 64'(exp_q.size()), 64'h0);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0;
      step(1);
      redirect_valid = 1'b0;
      chk("resume_halted", 64'(halted), 64'h0);
      exp_push(32'h0);
      exp_push(32'h4);
      exp_push(32'h8);
      step(5);
      chk("resume_drained", 64'(exp_q.size()), 64'h0);
      chk("rehalt", 64'(halted), 64'h1);
      eof_addr = 32'hFFFF_FFFF;

      // Misaligned redirect faults, aligned redirect recovers
      do_reset(1'b1);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h42;
      step(1);
      redirect_valid = 1'b0;
      step(3);
      chk("fault_state", {62'h0, fault, out_valid}, {62'h0, 1'b1, 1'b0});
      chk("fault_addr_hold", 64'(imem_addr), 64'h42);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h44;
      step(1);
      redirect_valid = 1'b0;
      chk("fault_clear", 64'(fault), 64'h0);
      exp_push(32'h44);
      exp_push(32'h48);
      step(3);
      out_ready = 1'b0;
      chk("fault_drained", 64'(exp_q.size()), 64'h0);

      // Asynchronous reset mid-cycle
      do_reset(1'b0);
      step(3);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_outs", {61'h0, out_valid, halted, fault}, 64'h0);
      chk("async_rst_addr", 64'(imem_addr), 64'h0);
`ifdef FETCH_PERF_EN
      chk("async_rst_perf", {perf_fetch_cnt, perf_stall_cnt}, 64'h0);
`endif
      step(2);
      rst_n = 1'b1;
      step(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
